button_event_ctrl: RTL and testbench
====================================

Name: button_event_ctrl

Overview:
- Turns N debounced button levels into timestamp-free user events: PRESS, RELEASE, LONG (held past a threshold) and REPEAT (auto-repeat while held).
- Each button has its own small FSM. A shared tick prescaler supplies the time base.
- A round-robin arbiter serialises all buttons onto one valid/ready event stream for the UI/menu logic.
- Sits directly downstream of the per-button debounce instances.

Parameters:
- NumButtons, 4, number of button inputs (>=1).
- TickDiv, 100000, clk cycles per timing tick (>=1; 1 means a tick every cycle).
- LongPressTicks, 500, ticks of continuous hold before LONG (>=1).
- RepeatTicks, 100, ticks between REPEAT events while in long-hold (>=1).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, block enable.
- btn, input, NumButtons, debounced button levels (1 = pressed).
- evt_valid, output, 1, event available.
- evt_ready, input, 1, consumer accepts the event when high together with evt_valid.
- evt_id, output, max(1,$clog2(NumButtons)), index of the button that produced the event.
- evt_kind, output, 2, event type: 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT.
- evt_drop, output, 1, one-cycle pulse when an event is lost.

Behaviour:
- **Reset (async assert, sync deassert handled upstream):**
  - evt_valid=0, evt_id=0, evt_kind=0, evt_drop=0.
  - All FSMs IDLE, btn history=0, pending slots empty, prescaler=0, RR pointer selects button 0 first.
  - A button held through reset produces PRESS after reset.
- **Prescaler:** counts 0..TickDiv-1 while enable=1; tick is a one-cycle pulse on wrap.
- **Per-button FSM** (evaluated on btn sampled vs its registered previous value):
  - IDLE: rising edge -> PRESSED, post PRESS, hold_cnt=0.
  - PRESSED: each tick hold_cnt++. On the tick where hold_cnt reaches LongPressTicks-1 -> LONG, post LONG, rep_cnt=0.
  - LONG: each tick rep_cnt++. At RepeatTicks-1, post REPEAT and rep_cnt=0.
  - Any state, btn low -> IDLE, post RELEASE. A release takes priority over a LONG/REPEAT due in the same cycle.
  - Counter widths are $clog2(param+1); counters never wrap past their terminal value.
- **Pending slots:** one slot per button holding the kind.
  - Post to an empty slot: fills it.
  - Post to a full slot: the event is discarded, the slot keeps its old contents, evt_drop pulses.
  - If the slot is being granted in the same cycle, the new event is stored and no drop occurs.
- **Output register / arbiter:**
  - When evt_valid=0, or evt_valid&&evt_ready, load the next pending slot, searching round-robin from (last granted + 1). Clear that slot.
  - evt_id and evt_kind are stable while evt_valid && !evt_ready.
  - Latency: btn first sampled high at edge k -> evt_valid high after edge k+2 (empty system, ready=1).
  - Throughput: one event per cycle.
- **enable=0:**
  - Prescaler held at 0; all FSMs forced to IDLE with no events posted; pending slots cleared.
  - btn history still tracks btn, so a button already held when enable rises produces no PRESS.
  - An in-flight evt_valid is held until accepted.
- **Simultaneous edges on several buttons:** all are posted in the same cycle and drained in RR order.

Optional Feature:
- BTN_EVT_REPEAT_EN
  - Defined: LONG state generates REPEAT every RepeatTicks as above.
  - Undefined: LONG is terminal until release, kind 3 is never produced, rep_cnt logic is removed and RepeatTicks is ignored.

Test Plan:
(NumButtons=4, TickDiv=4, LongPressTicks=3, RepeatTicks=2, evt_ready=1 unless stated.)
- btn[1] high for 8 cycles then low -> PRESS id1 two cycles after first sample; RELEASE id1 two cycles after the fall; no LONG.
- btn[0] held 40 cycles, macro defined -> PRESS, then LONG about 12 cycles later, then REPEAT every 8 cycles, then RELEASE. Macro undefined -> no REPEAT.
- btn[3:0] rise in the same cycle after reset -> PRESS ids 0,1,2,3 on consecutive cycles; next simultaneous release -> RELEASE 0,1,2,3 (pointer now after 3, wraps to 0).
- evt_ready=0; btn[2] press, release, press:
  - PRESS id2 is held stable on the output.
  - RELEASE fills the slot.
  - The second PRESS pulses evt_drop=1 for one cycle.
  - With ready=1: PRESS, then RELEASE delivered, no further event.
- rst_n low while btn[0] is in LONG and evt_valid=1 -> evt_valid=0 immediately (asynchronous). rst_n high with btn[0] still high -> PRESS id0 two cycles later.
- enable=0 while btn[1] is held and PRESSED -> no RELEASE, pending cleared. enable=1 with btn[1] still high -> no event until a new press.

Source files
------------

// File: rtl/button_event_ctrl.sv
// button_event_ctrl: turns N debounced button levels into PRESS / RELEASE /
// LONG / REPEAT events, serialised round-robin onto one valid/ready stream.
// Optional feature macro: BTN_EVT_REPEAT_EN (auto-repeat while long-held).
module button_event_ctrl #(
    parameter int NumButtons     = 4,
    parameter int TickDiv        = 100000,
    parameter int LongPressTicks = 500,
    parameter int RepeatTicks    = 100
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             enable,
    input  logic [NumButtons-1:0]                            btn,
    output logic                                             evt_valid,
    input  logic                                             evt_ready,
    output logic [((NumButtons > 1) ? $clog2(NumButtons) : 1)-1:0] evt_id,
    output logic [1:0]                                       evt_kind,
    output logic                                             evt_drop
);

    localparam int IdW = (NumButtons > 1) ? $clog2(NumButtons) : 1;
    localparam int PW  = (TickDiv > 1) ? $clog2(TickDiv) : 1;
    localparam int HW  = $clog2(LongPressTicks + 1);
    localparam logic [PW-1:0]  TickLast = PW'(TickDiv - 1);
    localparam logic [HW-1:0]  HoldLast = HW'(LongPressTicks - 1);
    localparam logic [IdW-1:0] LastInit = IdW'(NumButtons - 1);
`ifdef BTN_EVT_REPEAT_EN
    localparam int RW = $clog2(RepeatTicks + 1);
    localparam logic [RW-1:0] RepLast = RW'(RepeatTicks - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESSED,
        S_LONG
    } state_t;

    typedef enum logic [1:0] {
        K_PRESS   = 2'd0,
        K_RELEASE = 2'd1,
        K_LONG    = 2'd2,
        K_REPEAT  = 2'd3
    } kind_t;

    logic [PW-1:0]         cnt_q;
    logic                  tick;
    logic [NumButtons-1:0] btn_s;
    logic [NumButtons-1:0] btn_h;
    logic [NumButtons-1:0] rise;

    state_t                state_q   [NumButtons];
    state_t                state_d   [NumButtons];
    logic [HW-1:0]         hold_q    [NumButtons];
    logic [HW-1:0]         hold_d    [NumButtons];
`ifdef BTN_EVT_REPEAT_EN
    logic [RW-1:0]         rep_q     [NumButtons];
    logic [RW-1:0]         rep_d     [NumButtons];
`endif
    logic [NumButtons-1:0] post;
    kind_t                 post_kind [NumButtons];

    logic [NumButtons-1:0] slot_full;
    kind_t                 slot_kind [NumButtons];
    logic [NumButtons-1:0] pend;
    logic [NumButtons-1:0] drop;
    logic                  found;
    logic [IdW-1:0]        sel;
    logic [IdW-1:0]        last_q;
    logic                  load;
    logic                  grant;

    assign tick = enable && (cnt_q == TickLast);
    assign rise = btn_s & ~btn_h;

    // Shared time base: free-running divider, held at zero while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!enable || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Input sample and history; tracks btn even while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s <= '0;
            btn_h <= '0;
        end else begin
            btn_s <= btn;
            btn_h <= btn_s;
        end
    end

    // Per-button FSM state and hold/repeat counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NumButtons; i++) begin
                state_q[i] <= S_IDLE;
                hold_q[i]  <= '0;
`ifdef BTN_EVT_REPEAT_EN
                rep_q[i]   <= '0;
`endif
            end
        end else begin
            for (int unsigned i = 0; i < NumButtons; i++) begin
                state_q[i] <= state_d[i];
                hold_q[i]  <= hold_d[i];
`ifdef BTN_EVT_REPEAT_EN
                rep_q[i]   <= rep_d[i];
`endif
            end
        end
    end

    // Per-button next state and event posting; release beats LONG/REPEAT.
    always_comb begin
        for (int unsigned i = 0; i < NumButtons; i++) begin
            state_d[i]   = state_q[i];
            hold_d[i]    = hold_q[i];
`ifdef BTN_EVT_REPEAT_EN
            rep_d[i]     = rep_q[i];
`endif
            post[i]      = 1'b0;
            post_kind[i] = K_PRESS;
            if (!enable) begin
                state_d[i] = S_IDLE;
                hold_d[i]  = '0;
`ifdef BTN_EVT_REPEAT_EN
                rep_d[i]   = '0;
`endif
            end else begin
                case (state_q[i])
                    S_IDLE: begin
                        if (rise[i]) begin
                            state_d[i]   = S_PRESSED;
                            hold_d[i]    = '0;
                            post[i]      = 1'b1;
                            post_kind[i] = K_PRESS;
                        end
                    end
                    S_PRESSED: begin
                        if (!btn_s[i]) begin
                            state_d[i]   = S_IDLE;
                            post[i]      = 1'b1;
                            post_kind[i] = K_RELEASE;
                        end else if (tick) begin
                            if (hold_q[i] == HoldLast) begin
                                state_d[i]   = S_LONG;
`ifdef BTN_EVT_REPEAT_EN
                                rep_d[i]     = '0;
`endif
                                post[i]      = 1'b1;
                                post_kind[i] = K_LONG;
                            end else begin
                                hold_d[i] = hold_q[i] + 1'b1;
                            end
                        end
                    end
                    S_LONG: begin
                        if (!btn_s[i]) begin
                            state_d[i]   = S_IDLE;
                            post[i]      = 1'b1;
                            post_kind[i] = K_RELEASE;
                        end
`ifdef BTN_EVT_REPEAT_EN
                        else if (tick) begin
                            if (rep_q[i] == RepLast) begin
                                rep_d[i]     = '0;
                                post[i]      = 1'b1;
                                post_kind[i] = K_REPEAT;
                            end else begin
                                rep_d[i] = rep_q[i] + 1'b1;
                            end
                        end
`endif
                    end
                    default: begin
                        state_d[i] = S_IDLE;
                    end
                endcase
            end
        end
    end

    assign pend  = slot_full & {NumButtons{enable}};
    assign load  = !evt_valid || evt_ready;
    assign grant = load && found;

    // Round-robin search starting one past the last granted button.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        sel   = '0;
        for (int unsigned k = 1; k <= NumButtons; k++) begin
            idx = (int'(last_q) + k) % NumButtons;
            if (!found && pend[idx]) begin
                found = 1'b1;
                sel   = IdW'(idx);
            end
        end
    end

    // Drop detection: a post to an occupied slot that is not draining now.
    always_comb begin
        for (int unsigned i = 0; i < NumButtons; i++) begin
            drop[i] = enable && post[i] && slot_full[i] && !(grant && (sel == IdW'(i)));
        end
    end

    // Pending slots: a slot granted this cycle may be refilled in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NumButtons; i++) begin
                slot_full[i] <= 1'b0;
                slot_kind[i] <= K_PRESS;
            end
        end else begin
            for (int unsigned i = 0; i < NumButtons; i++) begin
                if (!enable) begin
                    slot_full[i] <= 1'b0;
                end else if (post[i] && !drop[i]) begin
                    slot_full[i] <= 1'b1;
                    slot_kind[i] <= post_kind[i];
                end else if (grant && (sel == IdW'(i))) begin
                    slot_full[i] <= 1'b0;
                end
            end
        end
    end

    // Output register: reload whenever empty or accepted; hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_kind  <= '0;
            evt_drop  <= 1'b0;
            last_q    <= LastInit;
        end else begin
            evt_drop <= |drop;
            if (load) begin
                evt_valid <= found;
                if (found) begin
                    evt_id   <= sel;
                    evt_kind <= slot_kind[sel];
                    last_q   <= sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Self-checking bench for button_event_ctrl (NumButtons=4, TickDiv=4,
// LongPressTicks=3, RepeatTicks=2). Honours BTN_EVT_REPEAT_EN if defined.
module tb_button_event_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] btn;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic [1:0] evt_kind;
    logic       evt_drop;

    int n_chk  = 0;
    int n_fail = 0;

    button_event_ctrl #(
        .NumButtons    (4),
        .TickDiv       (4),
        .LongPressTicks(3),
        .RepeatTicks   (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .btn      (btn),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_id   (evt_id),
        .evt_kind (evt_kind),
        .evt_drop (evt_drop)
    );

    always #5 clk = ~clk;

    // One row: inputs driven after a falling edge, outputs checked at the next one.
    typedef struct {
        bit         rst;
        bit         en;
        logic [3:0] b;
        bit         rdy;
        bit         v;
        logic [1:0] id;
        logic [1:0] kind;
        bit         drop;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rst, bit en, logic [3:0] b, bit rdy,
                                bit v, logic [1:0] id, logic [1:0] kind, bit drop);
        vec_t r;
        r.rst = rst; r.en = en; r.b = b; r.rdy = rdy;
        r.v = v; r.id = id; r.kind = kind; r.drop = drop;
        vecs.push_back(r);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        enable    = 1'b1;
        btn       = '0;
        evt_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int         ev_t[$];
    logic [1:0] ev_k[$];
    logic [1:0] ev_id[$];
    logic [1:0] exp_k[$];
    bit         found;
    int         t_long;

    initial begin
        // Press/release of button 1 without reaching LONG
        add(1, 1, 4'b0010, 1, 0, 0, 0, 0);
        add(0, 1, 4'b0010, 1, 0, 0, 0, 0);
        add(0, 1, 4'b0010, 1, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 4'b0010, 1, 0, 0, 0, 0);
        add(0, 1, 4'b0000, 1, 0, 0, 0, 0);
        add(0, 1, 4'b0000, 1, 0, 0, 0, 0);
        add(0, 1, 4'b0000, 1, 1, 1, 1, 0);
        add(0, 1, 4'b0000, 1, 0, 0, 0, 0);
        add(0, 1, 4'b0000, 1, 0, 0, 0, 0);
        // Simultaneous press then release on all buttons, drained in RR order
        add(1, 1, 4'b1111, 1, 0, 0, 0, 0);
        add(0, 1, 4'b1111, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 4'b1111, 1, 1, 2'(i), 0, 0);
        add(0, 1, 4'b1111, 1, 0, 0, 0, 0);
        add(0, 1, 4'b0000, 1, 0, 0, 0, 0);
        add(0, 1, 4'b0000, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 4'b0000, 1, 1, 2'(i), 1, 0);
        add(0, 1, 4'b0000, 1, 0, 0, 0, 0);
        // Stalled output, refill by RELEASE, second PRESS dropped
        add(1, 1, 4'b0100, 0, 0, 0, 0, 0);
        add(0, 1, 4'b0100, 0, 0, 0, 0, 0);
        add(0, 1, 4'b0100, 0, 1, 2, 0, 0);
        add(0, 1, 4'b0000, 0, 1, 2, 0, 0);
        add(0, 1, 4'b0000, 0, 1, 2, 0, 0);
        add(0, 1, 4'b0100, 0, 1, 2, 0, 0);
        add(0, 1, 4'b0100, 0, 1, 2, 0, 1);
        add(0, 1, 4'b0100, 0, 1, 2, 0, 0);
        add(0, 1, 4'b0100, 1, 1, 2, 1, 0);
        add(0, 1, 4'b0100, 1, 0, 0, 0, 0);
        add(0, 1, 4'b0100, 1, 0, 0, 0, 0);
        // enable=0 clears pending, holds in-flight event, suppresses RELEASE
        add(1, 1, 4'b0110, 0, 0, 0, 0, 0);
        add(0, 1, 4'b0110, 0, 0, 0, 0, 0);
        add(0, 1, 4'b0110, 0, 1, 1, 0, 0);
        add(0, 0, 4'b0110, 0, 1, 1, 0, 0);
        add(0, 0, 4'b0110, 1, 0, 0, 0, 0);
        add(0, 0, 4'b0110, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(0, 1, 4'b0110, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 4'b0000, 1, 0, 0, 0, 0);
        add(0, 1, 4'b0010, 1, 0, 0, 0, 0);
        add(0, 1, 4'b0010, 1, 0, 0, 0, 0);
        add(0, 1, 4'b0010, 1, 1, 1, 0, 0);
        add(0, 1, 4'b0010, 1, 0, 0, 0, 0);

        // Reset values while reset is asserted
        rst_n = 1'b0; enable = 1'b1; btn = '0; evt_ready = 1'b1;
        #1;
        chk("reset_valid", int'(evt_valid), 0);
        chk("reset_id",    int'(evt_id),    0);
        chk("reset_kind",  int'(evt_kind),  0);
        chk("reset_drop",  int'(evt_drop),  0);
        @(negedge clk);

        for (int r = 0; r < vecs.size(); r++) begin
            if (vecs[r].rst) do_reset();
            enable    = vecs[r].en;
            btn       = vecs[r].b;
            evt_ready = vecs[r].rdy;
            @(negedge clk);
            chk($sformatf("row%0d_valid", r), int'(evt_valid), int'(vecs[r].v));
            chk($sformatf("row%0d_drop", r),  int'(evt_drop),  int'(vecs[r].drop));
            if (vecs[r].v) begin
                chk($sformatf("row%0d_id", r),   int'(evt_id),   int'(vecs[r].id));
                chk($sformatf("row%0d_kind", r), int'(evt_kind), int'(vecs[r].kind));
            end
        end

        // Long hold on button 0: PRESS, LONG, (REPEATs), RELEASE
        do_reset();
        for (int c = 0; c < 48; c++) begin
            btn = (c < 40) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            if (evt_valid) begin
                ev_t.push_back(c);
                ev_k.push_back(evt_kind);
                ev_id.push_back(evt_id);
            end
        end
`ifdef BTN_EVT_REPEAT_EN
        exp_k = '{2'd0, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1};
`else
        exp_k = '{2'd0, 2'd2, 2'd1};
`endif
        chk("long_event_count", ev_t.size(), exp_k.size());
        for (int i = 0; i < ev_t.size() && i < exp_k.size(); i++) begin
            chk($sformatf("long_ev%0d_kind", i), int'(ev_k[i]), int'(exp_k[i]));
            chk($sformatf("long_ev%0d_id", i),   int'(ev_id[i]), 0);
        end
        if (ev_t.size() >= 3) begin
            chk("long_press_time", ev_t[0], 2);
            t_long = ev_t[1];
            chk("long_time_in_window", int'(t_long >= 11 && t_long <= 14), 1);
            for (int i = 2; i < ev_t.size() - 1; i++)
                chk($sformatf("repeat%0d_spacing", i - 1), ev_t[i] - ev_t[i-1], 8);
            chk("long_release_time", ev_t[ev_t.size()-1], 42);
        end

        // Asynchronous reset while LONG is on the output; press replays after reset
        do_reset();
        btn   = 4'b0001;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (evt_valid && evt_kind == 2'd2) found = 1'b1;
        end
        chk("long_seen_before_reset", int'(found), 1);
        evt_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", int'(evt_valid), 0);
        chk("async_reset_kind",  int'(evt_kind),  0);
        @(negedge clk);
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        @(negedge clk);
        chk("post_reset_c1_valid", int'(evt_valid), 0);
        @(negedge clk);
        chk("post_reset_c2_valid", int'(evt_valid), 0);
        @(negedge clk);
        chk("post_reset_c3_valid", int'(evt_valid), 1);
        chk("post_reset_c3_id",    int'(evt_id),    0);
        chk("post_reset_c3_kind",  int'(evt_kind),  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
